muldiv_hilo: RTL and testbench
==============================

# muldiv_hilo

Iterative multiply/divide unit with the architectural HI/LO registers for the MiniSys-1A CPU. It sits in the execute stage beside `alu_32` and takes the same one-hot instruction strobes from `decoder` (`op_mult`, `op_multu`, `op_div`, `op_divu`, `op_mfhi`, `op_mflo`, `op_mthi`, `op_mtlo`). It also takes the same operands (`alu_a` = rs, `alu_b` = rt). It executes 32-step shift-add multiplication and restoring division, raises `busy` so the pipeline can stall, and supplies HI/LO for `mfhi`/`mflo` writeback.

## Interface
- None: no parameters; width is fixed at 32.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `alu_a`  in  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- `alu_b`  in  32  rt operand (divisor / multiplier)
- `op_mult`, `op_multu`, `op_div`, `op_divu`  in  1 each  start strobes, one-hot
- `op_mthi`, `op_mtlo`  in  1 each  write rs into HI / LO
- `op_mfhi`, `op_mflo`  in  1 each  select HI / LO onto `q`
- `busy`  out  1  operation in progress (state != IDLE)
- `done`  out  1  one-cycle pulse after HI/LO are updated by mult/div
- `hi`, `lo`  out  32 each  architectural HI / LO registers
- `q`  out  32  combinational: `hi` if `op_mfhi`, else `lo` if `op_mflo`, else 0

## Operation
- States:
  - IDLE
  - MUL: 32 shift-add iterations
  - DIV: 32 restoring iterations
  - FIX: sign correction and HI/LO write
- Reset (async):
  - State goes to IDLE.
  - `hi`, `lo`, `done`, the iteration counter and all internal datapath registers go to 0.
  - `busy` = 0.
  - Reset asserted mid-operation abandons the operation; HI/LO are 0, not partial.
- In IDLE, on a rising edge with a start strobe:
  - Latch the magnitudes of both operands. Signed ops use the two's-complement absolute value; unsigned ops use the raw value.
  - Latch the result-sign flags and the divide-by-zero flag (`alu_b` == 0).
  - Set count = 0 and go to MUL or DIV.
- Priority if several strobes are high in IDLE (only for determinism; the decoder guarantees one-hot): mult > multu > div > divu > mthi > mtlo.
- `mthi`/`mtlo` in IDLE: HI (or LO) <= `alu_a` on that edge. No busy cycle and no `done` pulse.
- In MUL/DIV/FIX:
  - All start, mthi and mtlo strobes are ignored. The pipeline is required to stall on `busy`.
  - `q` still reflects the current `hi`/`lo` (old values until FIX).
- MUL: 64-bit accumulator. Each edge: if the multiplier LSB is 1, add the multiplicand into the upper half, then shift right by 1. After 32 iterations go to FIX.
- DIV: 64-bit remainder:quotient register, restoring. Each edge: shift left 1, trial-subtract the divisor from the upper 33 bits, and keep the result if it is non-negative, setting quotient bit 1. After 32 iterations go to FIX.
- FIX writes:
  - mult: {HI,LO} = negated 64-bit product if the operand signs differ (signed only).
  - div: LO = quotient, negated if the operand signs differ. HI = remainder, negated if the dividend was negative (signed only).
  - Divide by zero (signed or unsigned): HI = original `alu_a`, LO = 32'hFFFFFFFF.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This falls out of the magnitude datapath with no special case.
- After FIX, return to IDLE.

## Timing
- Start edge E0. Iteration edges E1..E32 (count 0..31; count==31 moves to FIX). E33 is the FIX edge and writes HI/LO.
- `busy` is high from after E0 through E33: 33 cycles. It is low in the cycle after E33.
- `done` is registered and high only in the cycle following E33.
- Back-to-back: a new start is accepted on the first edge after E33 (`busy` = 0). HI/LO written at E33 are visible on `q` in that cycle.
- mthi/mtlo latency is 1 edge. mfhi/mflo latency is 0 (combinational).

## Test plan
- multu `alu_a`=0xFFFFFFFF, `alu_b`=0xFFFFFFFF -> after 33 busy cycles, `done` pulses; HI=0xFFFFFFFE, LO=0x00000001.
- mult `alu_a`=0xFFFFFFFD (-3), `alu_b`=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; then op_mflo gives `q`=0xFFFFFFF1.
- div `alu_a`=0xFFFFFFF9 (-7), `alu_b`=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu 7/0 -> HI=7, LO=0xFFFFFFFF, still 33 busy cycles.
- Signed div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, no hang.
- mthi `alu_a`=0x12345678 in IDLE -> HI=0x12345678 next cycle, `busy` stays 0. Then start mult and pulse op_mtlo at E5 -> LO is unchanged by mtlo; only the FIX result is written.
- Start divu 100/7; assert `rst` at E10 -> asynchronously busy=0, HI=LO=0, done=0. After release, mult 6*7 gives LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_hilo_if.sv
// Operand, strobe and result bundle between the execute stage and muldiv_hilo.
// master drives operands/strobes; slave returns busy/done, HI/LO and the mfhi/mflo mux.
interface muldiv_hilo_if;
  localparam int unsigned W = 32;

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         op_mult;
  logic         op_multu;
  logic         op_div;
  logic         op_divu;
  logic         op_mthi;
  logic         op_mtlo;
  logic         op_mfhi;
  logic         op_mflo;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] q;

  modport master (
    output alu_a, alu_b, op_mult, op_multu, op_div, op_divu,
           op_mthi, op_mtlo, op_mfhi, op_mflo,
    input  busy, done, hi, lo, q
  );

  modport slave (
    input  alu_a, alu_b, op_mult, op_multu, op_div, op_divu,
           op_mthi, op_mtlo, op_mfhi, op_mflo,
    output busy, done, hi, lo, q
  );
endinterface

// File: rtl/muldiv_hilo.sv
// Iterative 32-step shift-add multiplier / restoring divider with HI/LO registers.
// Works on operand magnitudes; signs are applied in a single FIX cycle.
module muldiv_hilo (
  input  logic           clk,
  input  logic           rst,
  muldiv_hilo_if.slave   bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_count;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_opnd;
  logic [W-1:0]   r_a_raw;
  logic           r_is_div;
  logic           r_neg_q;
  logic           r_neg_r;
  logic           r_dz;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;
  logic           r_busy;
  logic           r_done;

  logic           w_start;
  logic           w_start_div;
  logic           w_signed;
  logic [W-1:0]   w_a_mag;
  logic [W-1:0]   w_b_mag;
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_nxt;
  logic           w_div_ge;
  logic [W-1:0]   w_div_diff;
  logic [2*W-1:0] w_div_nxt;
  logic [2*W-1:0] w_prod_fix;
  logic [W-1:0]   w_quo_fix;
  logic [W-1:0]   w_rem_fix;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state; start priority mult > multu > div > divu
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.op_mult || bus.op_multu)    w_state_nxt = MUL;
        else if (bus.op_div || bus.op_divu) w_state_nxt = DIV;
      end
      MUL, DIV: if (r_count == CW'(W-1)) w_state_nxt = FIX;
      FIX:      w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Operand conditioning, one iteration step of each datapath, and sign fix-up
  always_comb begin
    w_start     = bus.op_mult || bus.op_multu || bus.op_div || bus.op_divu;
    w_start_div = !bus.op_mult && !bus.op_multu && (bus.op_div || bus.op_divu);
    w_signed    = bus.op_mult || (!bus.op_multu && bus.op_div);
    w_a_mag     = (w_signed && bus.alu_a[W-1]) ? W'(-bus.alu_a) : bus.alu_a;
    w_b_mag     = (w_signed && bus.alu_b[W-1]) ? W'(-bus.alu_b) : bus.alu_b;

    w_mul_sum   = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_opnd};
    w_mul_nxt   = r_acc[0] ? {w_mul_sum, r_acc[W-1:1]} : {1'b0, r_acc[2*W-1:1]};

    // Partial remainder is always below the divisor, so the difference fits in W bits
    w_div_ge    = (r_acc[2*W-1:W-1] >= {1'b0, r_opnd});
    w_div_diff  = W'(r_acc[2*W-2:W-1] - r_opnd);
    w_div_nxt   = w_div_ge ? {w_div_diff, r_acc[W-2:0], 1'b1} : {r_acc[2*W-2:0], 1'b0};

    w_prod_fix  = r_neg_q ? (2*W)'(-r_acc) : r_acc;
    w_quo_fix   = r_neg_q ? W'(-r_acc[W-1:0]) : r_acc[W-1:0];
    w_rem_fix   = r_neg_r ? W'(-r_acc[2*W-1:W]) : r_acc[2*W-1:W];
  end

  // Datapath, HI/LO and registered status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_a_raw  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (r_state == FIX);
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (w_start) begin
            r_acc    <= {W'(0), (w_start_div ? w_a_mag : w_b_mag)};
            r_opnd   <= w_start_div ? w_b_mag : w_a_mag;
            r_a_raw  <= bus.alu_a;
            r_is_div <= w_start_div;
            r_neg_q  <= w_signed && (bus.alu_a[W-1] ^ bus.alu_b[W-1]);
            r_neg_r  <= w_signed && bus.alu_a[W-1];
            r_dz     <= (bus.alu_b == '0);
          end else if (bus.op_mthi) begin
            r_hi <= bus.alu_a;
          end else if (bus.op_mtlo) begin
            r_lo <= bus.alu_a;
          end
        end
        MUL: begin
          r_acc   <= w_mul_nxt;
          r_count <= r_count + CW'(1);
        end
        DIV: begin
          r_acc   <= w_div_nxt;
          r_count <= r_count + CW'(1);
        end
        FIX: begin
          if (!r_is_div) begin
            r_hi <= w_prod_fix[2*W-1:W];
            r_lo <= w_prod_fix[W-1:0];
          end else if (r_dz) begin
            r_hi <= r_a_raw;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.q    = bus.op_mfhi ? r_hi : (bus.op_mflo ? r_lo : '0);
endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed and randomized bench for muldiv_hilo; expected HI/LO come from
// plain 64-bit arithmetic on the operands.
module tb_muldiv_hilo;
  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  muldiv_hilo_if bus();

  muldiv_hilo u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result {HI,LO}
  function automatic logic [63:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'h0)   return {a, 32'hFFFF_FFFF};
        if (op == OP_DIV) return {32'(sa % sb), 32'(sa / sb)};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic set_strobe(input int op, input logic v);
    case (op)
      OP_MULT:  bus.op_mult  = v;
      OP_MULTU: bus.op_multu = v;
      OP_DIV:   bus.op_div   = v;
      default:  bus.op_divu  = v;
    endcase
  endtask

  // Leaves the bench at the falling edge just after the start edge
  task automatic start_op(input int op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.alu_a = a;
    bus.alu_b = b;
    set_strobe(op, 1'b1);
    @(negedge clk);
    set_strobe(op, 1'b0);
  endtask

  // Counts remaining busy cycles, then checks done, HI/LO and the q mux
  task automatic finish_op(input int op, input logic [31:0] a, input logic [31:0] b,
                           input int already, input string tag);
    int cycles;
    logic [63:0] exp;
    exp = model(op, a, b);
    cycles = already;
    while (bus.busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    check({tag, ".busy_cycles"}, 32'(cycles), 32'd33);
    check({tag, ".done"}, 32'(bus.done), 32'd1);
    check({tag, ".hi"}, bus.hi, exp[63:32]);
    check({tag, ".lo"}, bus.lo, exp[31:0]);
    bus.op_mfhi = 1'b1;
    #1 check({tag, ".q_mfhi"}, bus.q, exp[63:32]);
    bus.op_mfhi = 1'b0;
    bus.op_mflo = 1'b1;
    #1 check({tag, ".q_mflo"}, bus.q, exp[31:0]);
    bus.op_mflo = 1'b0;
    #1 check({tag, ".q_none"}, bus.q, 32'h0);
    @(negedge clk);
    check({tag, ".done_drop"}, 32'(bus.done), 32'd0);
  endtask

  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b, input string tag);
    start_op(op, a, b);
    finish_op(op, a, b, 0, tag);
  endtask

  initial begin
    logic [31:0] ra, rb, lo_before;
    int rop;

    bus.alu_a = '0;   bus.alu_b = '0;
    bus.op_mult = 0;  bus.op_multu = 0; bus.op_div = 0;  bus.op_divu = 0;
    bus.op_mthi = 0;  bus.op_mtlo = 0;  bus.op_mfhi = 0; bus.op_mflo = 0;

    repeat (2) @(negedge clk);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.hi", bus.hi, 32'h0);
    check("rst.lo", bus.lo, 32'h0);
    rst = 1'b0;

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_max.hi_const", bus.hi, 32'hFFFF_FFFE);
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg");
    check("mult_neg.lo_const", bus.lo, 32'hFFFF_FFF1);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    check("div_neg.lo_const", bus.lo, 32'hFFFF_FFFD);
    do_op(OP_DIVU, 32'd7, 32'd0, "divu_zero");
    check("divu_zero.hi_const", bus.hi, 32'd7);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf.lo_const", bus.lo, 32'h8000_0000);
    do_op(OP_DIV, 32'h8000_0001, 32'd0, "div_zero");

    // mthi in IDLE: one-edge latency, no busy
    @(negedge clk);
    bus.alu_a = 32'h1234_5678;
    bus.op_mthi = 1'b1;
    @(negedge clk);
    bus.op_mthi = 1'b0;
    check("mthi.hi", bus.hi, 32'h1234_5678);
    check("mthi.busy", 32'(bus.busy), 32'd0);
    check("mthi.done", 32'(bus.done), 32'd0);

    // mtlo during MUL must be ignored
    lo_before = bus.lo;
    start_op(OP_MULT, 32'd1000, 32'hFFFF_FF00);
    repeat (4) @(negedge clk);
    bus.alu_a = 32'hDEAD_BEEF;
    bus.op_mtlo = 1'b1;
    @(negedge clk);
    bus.op_mtlo = 1'b0;
    check("mtlo_busy.lo_held", bus.lo, lo_before);
    bus.alu_a = 32'd1000;
    finish_op(OP_MULT, 32'd1000, 32'hFFFF_FF00, 5, "mtlo_busy");

    for (int i = 0; i < 40; i++) begin
      rop = int'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1, 2:    rb = 32'($urandom_range(1, 15));
        3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
    end

    // Async reset mid-divide abandons the operation
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid.busy", 32'(bus.busy), 32'd0);
    check("rst_mid.done", 32'(bus.done), 32'd0);
    check("rst_mid.hi", bus.hi, 32'h0);
    check("rst_mid.lo", bus.lo, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_op(OP_MULT, 32'd6, 32'd7, "mult_after_rst");
    check("mult_after_rst.lo_const", bus.lo, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
